// File: rtl/exp_pipe.sv
// -----------------------------------------------------------------------------
// exp_pipe -- 3-stage, LANES-wide bfloat16 exp(x) / exp(-x) pipeline.
//
// Each lane classifies its operand (NaN, overflow/underflow, |x| tiny), and
// for the 13 exponents where the result actually varies it approximates the
// function piecewise-linearly: result = base +/- (mantissa * offset) >> 7,
// with base/offset picked by exponent and effective sign.
//
//   S1  capture operands and mode
//   S2  classify, table lookup, mantissa * offset
//   S3  add (positive) / subtract (negative), saturate, register result
//
// A single advance enable moves every stage at once, so a stalled output
// freezes the whole pipe; bubbles travel through and are never compacted.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset (clears valid bits and out_data)
//   in_valid   input beat present
//   in_ready   pipe can advance this cycle (beat accepted on valid & ready)
//   in_mode    0 = exp(x), 1 = exp(-x), travels with its beat
//   in_data    LANES bf16 operands, lane k at [16k+15:16k]
//   out_valid  result beat present
//   out_ready  result consumed on valid & ready
//   out_data   LANES bf16 results, same packing
// -----------------------------------------------------------------------------
module exp_pipe #(
   parameter int LANES = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 in_mode,
   input  logic [16*LANES-1:0]  in_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [16*LANES-1:0]  out_data
);

   // Per-lane S2 -> S3 payload. bypass marks results fixed by classification,
   // in which case base already holds the final value.
   typedef struct packed {
      logic        bypass;
      logic        neg;
      logic [15:0] base;
      logic [13:0] d;
   } s2_lane_t;

   // {base, offset} for exponents 121..133, positive and negative sign.
   function automatic logic [29:0] lut_entry(input logic neg, input logic [7:0] e);
      logic [29:0] pos_v;
      logic [29:0] neg_v;
      // NOTE: both outputs get a default before the case so unlisted exponents
      // never leave a path unassigned (which would infer a latch in comb code).
      pos_v = '0;
      neg_v = '0;
      case (e)
         8'd121: begin pos_v = {16'h3F82, 14'd2};     neg_v = {16'h3F7C, 14'd4};     end
         8'd122: begin pos_v = {16'h3F84, 14'd4};     neg_v = {16'h3F78, 14'd8};     end
         8'd123: begin pos_v = {16'h3F88, 14'd9};     neg_v = {16'h3F70, 14'd15};    end
         8'd124: begin pos_v = {16'h3F91, 14'd19};    neg_v = {16'h3F61, 14'd26};    end
         8'd125: begin pos_v = {16'h3FA4, 14'd47};    neg_v = {16'h3F47, 14'd44};    end
         8'd126: begin pos_v = {16'h3FD3, 14'd90};    neg_v = {16'h3F1B, 14'd95};    end
         8'd127: begin pos_v = {16'h402D, 14'd191};   neg_v = {16'h3EBC, 14'd178};   end
         8'd128: begin pos_v = {16'h40EC, 14'd366};   neg_v = {16'h3E0A, 14'd372};   end
         8'd129: begin pos_v = {16'h425A, 14'd736};   neg_v = {16'h3C96, 14'd743};   end
         8'd130: begin pos_v = {16'h453A, 14'd1485};  neg_v = {16'h39AF, 14'd1470};  end
         8'd131: begin pos_v = {16'h4B07, 14'd2952};  neg_v = {16'h33F1, 14'd2957};  end
         8'd132: begin pos_v = {16'h568F, 14'd5906};  neg_v = {16'h2864, 14'd5913};  end
         8'd133: begin pos_v = {16'h6DA1, 14'd11817}; neg_v = {16'h114B, 14'd11818}; end
         default: ;
      endcase
      return neg ? neg_v : pos_v;
   endfunction

   // S2 work for one lane: classify, look up, scale the mantissa.
   function automatic s2_lane_t stage2(input logic [15:0] x, input logic mode);
      logic        neg;
      logic [7:0]  e;
      logic [6:0]  m;
      logic [29:0] entry;
      s2_lane_t    r;
      // NOTE: blocking assignments are right for function temporaries; every
      // register in this module is updated with <= in its always_ff.
      neg      = x[15] ^ mode;
      e        = x[14:7];
      m        = x[6:0];
      entry    = lut_entry(neg, e);
      r.bypass = 1'b1;
      r.neg    = neg;
      r.base   = 16'h3F80;             // |x| small enough that the result is 1.0
      r.d      = '0;
      if (e == 8'hFF && m != 7'd0) begin
         r.base = 16'h7FC0;             // canonical quiet NaN
      end else if (e > 8'd133) begin
         r.base = neg ? 16'h0000 : 16'h7F80;
      end else if (e > 8'd120) begin
         r.bypass = 1'b0;
         r.base   = entry[29:14];
         r.d      = 14'((21'(m) * 21'(entry[13:0])) >> 7);
      end
      return r;
   endfunction

   // S3 work for one lane: apply the correction and clamp to the bf16 range.
   function automatic logic [15:0] stage3(input s2_lane_t l);
      logic [16:0] sum;
      logic [15:0] r;
      sum = {1'b0, l.base} + {3'b000, l.d};
      if (l.bypass)
         r = l.base;
      else if (!l.neg)
         r = (sum > 17'h07F7F) ? 16'h7F80 : sum[15:0];   // past max finite -> +inf
      else
         r = ({2'b00, l.d} > l.base) ? 16'h0000 : l.base - {2'b00, l.d};
      return r;
   endfunction

   logic                en;
   logic                s1_valid, s2_valid, s3_valid;
   logic                s1_mode;
   logic [16*LANES-1:0] s1_data;
   s2_lane_t            s2_lane [LANES];

   // Only a full, unconsumed output stage can stop the pipe.
   assign en        = out_ready | ~s3_valid;
   assign in_ready  = en;
   assign out_valid = s3_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s2_valid <= 1'b0;
         s3_valid <= 1'b0;
      end else if (en) begin
         s1_valid <= in_valid;
         s2_valid <= s1_valid;
         s3_valid <= s2_valid;
      end
   end

   // NOTE: S1/S2 payload is qualified by the valid bits, so it carries no
   // reset; only state visible at the ports (valids, out_data) is cleared.
   always_ff @(posedge clk) begin
      if (en) begin
         s1_mode <= in_mode;
         s1_data <= in_data;
         for (int k = 0; k < LANES; k++)
            s2_lane[k] <= stage2(s1_data[16*k +: 16], s1_mode);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data <= '0;
      end else if (en) begin
         for (int k = 0; k < LANES; k++)
            out_data[16*k +: 16] <= stage3(s2_lane[k]);
      end
   end

endmodule

// File: tb/tb_exp_pipe.sv
// -----------------------------------------------------------------------------
// tb_exp_pipe -- self-checking bench for exp_pipe.
//
// Two instances share handshake inputs: a 4-lane one and a 1-lane one fed with
// lane 0. Every accepted beat is turned into an expected result by a plain
// arithmetic model of the exp rules and queued; every consumed beat is
// compared against the queue head. Directed steps then pin latency,
// backpressure, reset and the documented example values.
// -----------------------------------------------------------------------------
module tb_exp_pipe;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_mode;
   logic [63:0] in_data;
   logic        out_ready;
   logic        in_ready,  out_valid;
   logic [63:0] out_data;
   logic        in_ready1, out_valid1;
   logic [15:0] out_data1;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [63:0] q[$];
   bit          hold_due = 1'b0;

   exp_pipe #(.LANES(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_mode(in_mode), .in_data(in_data), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data));

   exp_pipe #(.LANES(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
      .in_mode(in_mode), .in_data(in_data[15:0]), .out_valid(out_valid1),
      .out_ready(out_ready), .out_data(out_data1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Piecewise-linear table, index = exponent - 121.
   int base_p [13] = '{'h3F82, 'h3F84, 'h3F88, 'h3F91, 'h3FA4, 'h3FD3, 'h402D,
                       'h40EC, 'h425A, 'h453A, 'h4B07, 'h568F, 'h6DA1};
   int off_p  [13] = '{2, 4, 9, 19, 47, 90, 191, 366, 736, 1485, 2952, 5906, 11817};
   int base_n [13] = '{'h3F7C, 'h3F78, 'h3F70, 'h3F61, 'h3F47, 'h3F1B, 'h3EBC,
                       'h3E0A, 'h3C96, 'h39AF, 'h33F1, 'h2864, 'h114B};
   int off_n  [13] = '{4, 8, 15, 26, 44, 95, 178, 372, 743, 1470, 2957, 5913, 11818};

   function automatic logic [15:0] ref_exp(input logic [15:0] x, input logic mode);
      int s, e, m, base, off, d, r;
      s = int'(x[15] ^ mode);
      e = int'(x[14:7]);
      m = int'(x[6:0]);
      if (e == 255 && m != 0) return 16'h7FC0;
      if (e > 133)            return (s != 0) ? 16'h0000 : 16'h7F80;
      if (e <= 120)           return 16'h3F80;
      base = (s != 0) ? base_n[e-121] : base_p[e-121];
      off  = (s != 0) ? off_n[e-121]  : off_p[e-121];
      d    = (m * off) / 128;
      if (s == 0) begin
         r = base + d;
         if (r > 'h7F7F) r = 'h7F80;
      end else begin
         r = (d > base) ? 0 : base - d;
      end
      return r[15:0];
   endfunction

   function automatic logic [63:0] model_vec(input logic [63:0] d, input logic mode);
      logic [63:0] r;
      for (int k = 0; k < 4; k++) r[16*k +: 16] = ref_exp(d[16*k +: 16], mode);
      return r;
   endfunction

   // Operands biased toward the interesting exponent window and specials.
   function automatic logic [15:0] rand_bf16();
      int          sel;
      logic [7:0]  e;
      logic [6:0]  m;
      logic        s;
      sel = $urandom_range(0, 9);
      if (sel <= 5)      e = 8'($urandom_range(119, 135));
      else if (sel == 6) e = 8'hFF;
      else if (sel == 7) e = 8'h00;
      else               e = 8'($urandom_range(0, 255));
      m = 7'($urandom_range(0, 127));
      s = 1'($urandom_range(0, 1));
      return {s, e, m};
   endfunction

   function automatic logic [63:0] rand_vec();
      return {rand_bf16(), rand_bf16(), rand_bf16(), rand_bf16()};
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock: scoreboard work at the falling edge, return 1 time unit after
   // the rising edge so the caller can drive inputs and sample outputs.
   task automatic tick();
      logic [63:0] exp;
      @(negedge clk);
      if (rst_n) begin
         if (hold_due) check("hold_valid", {63'd0, out_valid}, 64'd1);
         if (out_valid) begin
            if (q.size() == 0) begin
               check("spurious_out", {63'd0, out_valid}, 64'd0);
            end else if (!out_ready) begin
               check("hold_data", out_data, q[0]);
               check("hold_data_l1", {48'd0, out_data1}, {48'd0, q[0][15:0]});
            end else begin
               exp = q.pop_front();
               check("out_data", out_data, exp);
               check("out_data_l1", {48'd0, out_data1}, {48'd0, exp[15:0]});
               check("out_valid_l1", {63'd0, out_valid1}, 64'd1);
            end
         end
         hold_due = out_valid && !out_ready;
         if (in_valid && in_ready) q.push_back(model_vec(in_data, in_mode));
      end else begin
         hold_due = 1'b0;
      end
      @(posedge clk);
      #1;
   endtask

   // Single beat into an idle pipe: latency and spec-given result on lane 0.
   task automatic send_and_wait(input string tag, input logic [15:0] x,
                                input logic mode, input logic [15:0] exp);
      int lat;
      in_data   = {rand_bf16(), rand_bf16(), rand_bf16(), x};
      in_mode   = mode;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      tick();
      in_valid  = 1'b0;
      in_data   = rand_vec();     // beat already captured; must not matter
      in_mode   = ~mode;
      lat = 1;
      while (!out_valid && lat < 10) begin
         tick();
         lat++;
      end
      check({tag, "_lat"}, 64'(lat), 64'd3);
      check(tag, {48'd0, out_data[15:0]}, {48'd0, exp});
      check({tag, "_l1"}, {48'd0, out_data1}, {48'd0, exp});
      tick();
   endtask

   typedef struct packed {
      logic [15:0] x;
      logic        mode;
      logic [15:0] exp;
   } dir_t;

   dir_t dir_vec [19] = '{
      '{16'h3F80, 1'b0, 16'h402D}, '{16'h3F80, 1'b1, 16'h3EBC}, '{16'hBF80, 1'b0, 16'h3EBC},
      '{16'h3FC0, 1'b0, 16'h408C}, '{16'h4000, 1'b0, 16'h40EC}, '{16'h7FC1, 1'b0, 16'h7FC0},
      '{16'h7FC1, 1'b1, 16'h7FC0}, '{16'hFF80, 1'b0, 16'h0000}, '{16'h7F80, 1'b0, 16'h7F80},
      '{16'h7F80, 1'b1, 16'h0000}, '{16'h3C00, 1'b0, 16'h3F80}, '{16'h0000, 1'b0, 16'h3F80},
      '{16'h0000, 1'b1, 16'h3F80}, '{16'hC2FF, 1'b0, 16'h0000}, '{16'h42FF, 1'b0, 16'h7F80},
      '{16'h3C7F, 1'b0, 16'h3F80}, '{16'h3C80, 1'b0, 16'h3F82}, '{16'h4300, 1'b0, 16'h7F80},
      '{16'h4300, 1'b1, 16'h0000}
   };

   initial begin
      logic [63:0] bp_data [4];
      logic        bp_mode [4];
      int          acc;
      int          budget;

      // ---- reset state ----
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_mode   = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      #12;
      check("rst_out_valid", {63'd0, out_valid},  64'd0);
      check("rst_in_ready",  {63'd0, in_ready},   64'd1);
      check("rst_out_data",  out_data,            64'd0);
      check("rst_out_data1", {48'd0, out_data1},  64'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick();

      // ---- documented examples, specials, saturation, exponent edges ----
      for (int i = 0; i < 19; i++)
         send_and_wait($sformatf("dir%0d", i), dir_vec[i].x, dir_vec[i].mode, dir_vec[i].exp);

      // ---- backpressure: output blocked for cycles 0..7 ----
      for (int i = 0; i < 4; i++) begin
         bp_data[i] = rand_vec();
         bp_mode[i] = 1'($urandom_range(0, 1));
      end
      out_ready = 1'b0;
      acc = 0;
      for (int cyc = 0; cyc < 8; cyc++) begin
         in_valid = (acc < 4);
         if (acc < 4) begin
            in_data = bp_data[acc];
            in_mode = bp_mode[acc];
         end
         check($sformatf("bp_rdy_c%0d", cyc), {63'd0, in_ready}, (cyc < 3) ? 64'd1 : 64'd0);
         check($sformatf("bp_rdy1_c%0d", cyc), {63'd0, in_ready1}, (cyc < 3) ? 64'd1 : 64'd0);
         if (in_valid && in_ready) acc++;
         tick();
      end
      check("bp_accepted", 64'(acc), 64'd3);
      out_ready = 1'b1;
      budget = 0;
      while ((acc < 4 || q.size() != 0) && budget < 20) begin
         in_valid = (acc < 4);
         if (acc < 4) begin
            in_data = bp_data[acc];
            in_mode = bp_mode[acc];
         end
         if (in_valid && in_ready) acc++;
         tick();
         budget++;
      end
      in_valid = 1'b0;
      check("bp_all_accepted", 64'(acc), 64'd4);
      check("bp_drained", 64'(q.size()), 64'd0);

      // ---- reset with three beats in flight ----
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         in_data  = rand_vec();
         in_mode  = 1'($urandom_range(0, 1));
         tick();
      end
      in_valid = 1'b0;
      check("mid_pre_valid", {63'd0, out_valid}, 64'd1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid",  {63'd0, out_valid},  64'd0);
      check("mid_rst_valid1", {63'd0, out_valid1}, 64'd0);
      check("mid_rst_ready",  {63'd0, in_ready},   64'd1);
      check("mid_rst_data",   out_data,            64'd0);
      q.delete();
      tick();
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         check("mid_no_stale",  {63'd0, out_valid},  64'd0);
         check("mid_no_stale1", {63'd0, out_valid1}, 64'd0);
      end
      send_and_wait("mid_first", 16'h3F80, 1'b0, 16'h402D);

      // ---- randomized traffic with random backpressure and one reset ----
      for (int cyc = 0; cyc < 400; cyc++) begin
         in_valid  = ($urandom_range(0, 9) < 7);
         in_data   = rand_vec();
         in_mode   = 1'($urandom_range(0, 1));
         out_ready = ($urandom_range(0, 9) < 7);
         if (cyc == 200) begin
            rst_n = 1'b0;
            #1;
            check("rnd_rst_valid", {63'd0, out_valid}, 64'd0);
            q.delete();
            tick();
            rst_n = 1'b1;
         end else begin
            tick();
         end
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      budget = 0;
      while (q.size() != 0 && budget < 20) begin
         tick();
         budget++;
      end
      check("rnd_drained", 64'(q.size()), 64'd0);
      tick();
      check("end_idle", {63'd0, out_valid}, 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
